// File: rtl/telemetry_uart_tx.sv
// telemetry_uart_tx: on a send request, snapshots the ride counter's nine
// ASCII digit fields and serialises one fixed 20-character line over 8N1 UART.
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   send           frame request, sampled on posedge clk
//   mins/tens/ones ASCII time digits (M, S-tens, S-ones)
//   dist_*         ASCII distance digits (thousands .. ones)
//   speed_*        ASCII speed digits (tens, ones)
//   tx             UART line, idle high, driven from a flop
//   busy           high while a frame is in flight
//   frame_done     one-cycle pulse when the last stop bit completes
//   overrun        one-cycle pulse when a send arrives while busy
//
// Line layout: "T=M:SS D=dddd V=vv\r\n"

module telemetry_uart_tx #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       send,
    input  logic [6:0] mins,
    input  logic [6:0] tens,
    input  logic [6:0] ones,
    input  logic [6:0] dist_thousands,
    input  logic [6:0] dist_hundreds,
    input  logic [6:0] dist_tens,
    input  logic [6:0] dist_ones,
    input  logic [6:0] speed_tens,
    input  logic [6:0] speed_ones,
    output logic       tx,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [4:0]    LAST_CHAR = 5'd19;
    localparam logic [2:0]    LAST_BIT  = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [BW-1:0] baud;
    logic [BW-1:0] baud_d;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_d;
    logic [4:0]    char_idx;
    logic [4:0]    char_idx_d;
    logic          bit_done;
    logic          accept;
    logic          tx_d;
    logic          frame_done_d;
    logic          overrun_d;
    logic [6:0]    char7;
    logic [7:0]    char_byte;

    // Snapshot of the digit fields, frozen at the accepting edge
    logic [6:0] s_mins;
    logic [6:0] s_tens;
    logic [6:0] s_ones;
    logic [6:0] s_dth;
    logic [6:0] s_dhu;
    logic [6:0] s_dte;
    logic [6:0] s_don;
    logic [6:0] s_ste;
    logic [6:0] s_son;

    assign bit_done = (baud == BAUD_LAST);
    assign accept   = (state == IDLE) && send;

    // ------------------------------------------------------------------
    // State register (all sequential state lives here)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            baud       <= '0;
            bit_idx    <= '0;
            char_idx   <= '0;
            tx         <= 1'b1;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            s_mins     <= '0;
            s_tens     <= '0;
            s_ones     <= '0;
            s_dth      <= '0;
            s_dhu      <= '0;
            s_dte      <= '0;
            s_don      <= '0;
            s_ste      <= '0;
            s_son      <= '0;
        end else begin
            state      <= state_d;
            baud       <= baud_d;
            bit_idx    <= bit_idx_d;
            char_idx   <= char_idx_d;
            tx         <= tx_d;
            frame_done <= frame_done_d;
            overrun    <= overrun_d;
            if (accept) begin
                s_mins <= mins;
                s_tens <= tens;
                s_ones <= ones;
                s_dth  <= dist_thousands;
                s_dhu  <= dist_hundreds;
                s_dte  <= dist_tens;
                s_don  <= dist_ones;
                s_ste  <= speed_tens;
                s_son  <= speed_ones;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state;
        baud_d     = bit_done ? '0 : baud + 1'b1;
        bit_idx_d  = bit_idx;
        char_idx_d = char_idx;
        unique case (state)
            IDLE: begin
                // Baud counter parked at zero so START gets a full bit
                baud_d = '0;
                if (send) begin
                    state_d    = START;
                    bit_idx_d  = '0;
                    char_idx_d = '0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (char_idx == LAST_CHAR) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = START;
                        char_idx_d = char_idx + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Character selection for the current char index
    // ------------------------------------------------------------------
    always_comb begin
        char7 = 7'h00;
        case (char_idx)
            5'd0:    char7 = 7'h54;  // 'T'
            5'd1:    char7 = 7'h3D;  // '='
            5'd2:    char7 = s_mins;
            5'd3:    char7 = 7'h3A;  // ':'
            5'd4:    char7 = s_tens;
            5'd5:    char7 = s_ones;
            5'd6:    char7 = 7'h20;  // ' '
            5'd7:    char7 = 7'h44;  // 'D'
            5'd8:    char7 = 7'h3D;
            5'd9:    char7 = s_dth;
            5'd10:   char7 = s_dhu;
            5'd11:   char7 = s_dte;
            5'd12:   char7 = s_don;
            5'd13:   char7 = 7'h20;
            5'd14:   char7 = 7'h56;  // 'V'
            5'd15:   char7 = 7'h3D;
            5'd16:   char7 = s_ste;
            5'd17:   char7 = s_son;
            5'd18:   char7 = 7'h0D;
            5'd19:   char7 = 7'h0A;
            default: char7 = 7'h00;
        endcase
        char_byte = {1'b0, char7};
    end

    // ------------------------------------------------------------------
    // Output logic. tx is precomputed from the next state and then
    // registered so the pin never sees combinational glitches.
    // ------------------------------------------------------------------
    always_comb begin
        busy         = (state != IDLE);
        overrun_d    = send && (state != IDLE);
        frame_done_d = (state == STOP) && bit_done
                       && (char_idx == LAST_CHAR);
        tx_d         = 1'b1;
        unique case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = char_byte[bit_idx_d];
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

endmodule
